// File: rtl/pc_sequencer.sv
// Program counter sequencer: next-PC selection, wfi sleep/irq wake and rfi return.
// Optional build macro PCSEQ_PREEMPT_EN lets irq preempt a retiring instruction in RUN.
module pc_sequencer #(
  parameter int unsigned          ADDR_W       = 8,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0]    IRQ_VECTOR   = ADDR_W'('hF0)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic [1:0]        pc_mux,
  input  logic              pc_save,
  input  logic              skip,
  input  logic [ADDR_W-1:0] wreg,
  input  logic [ADDR_W-1:0] literal,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              in_isr,
  output logic              irq_ack
);

  typedef enum logic [1:0] {StRun, StWait, StIsr} state_e;

  localparam logic [1:0] MuxAdd  = 2'd0;
  localparam logic [1:0] MuxWreg = 2'd1;
  localparam logic [1:0] MuxLit  = 2'd2;
  localparam logic [1:0] MuxSave = 2'd3;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
  logic              irq_ack_q, irq_ack_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] seq_pc;
  logic              is_wfi, is_rfi;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign is_wfi = (pc_mux == MuxSave) && pc_save;
  assign is_rfi = (pc_mux == MuxSave) && !pc_save;

  // PC the instruction produces when SAVE has no special meaning in this state.
  always_comb begin
    seq_pc = pc_inc;
    unique case (pc_mux)
      MuxAdd:  seq_pc = pc_inc + ADDR_W'(skip);
      MuxWreg: seq_pc = wreg;
      MuxLit:  seq_pc = literal;
      MuxSave: seq_pc = pc_inc;
      default: seq_pc = pc_inc;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    irq_ack_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (step) begin
`ifdef PCSEQ_PREEMPT_EN
          if (irq) begin
            saved_pc_d = seq_pc;
            pc_d       = IRQ_VECTOR;
            state_d    = StIsr;
            irq_ack_d  = 1'b1;
          end else
`endif
          if (is_wfi) begin
            saved_pc_d = pc_inc;
            state_d    = StWait;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      StWait: begin
        if (irq) begin
          pc_d      = IRQ_VECTOR;
          state_d   = StIsr;
          irq_ack_d = 1'b1;
        end
      end
      StIsr: begin
        if (step) begin
          if (is_rfi) begin
            pc_d    = saved_pc_q;
            state_d = StRun;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_VECTOR;
      saved_pc_q <= '0;
      irq_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      irq_ack_q  <= irq_ack_d;
    end
  end

  assign pc       = pc_q;
  assign fetch_en = (state_q != StWait);
  assign in_isr   = (state_q == StIsr);
  assign irq_ack  = irq_ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences,
// then random stimulus against an instruction-level reference model.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       step;
  logic [1:0] pc_mux;
  logic       pc_save;
  logic       skip;
  logic [7:0] wreg;
  logic [7:0] literal;
  logic       irq;
  logic [7:0] pc;
  logic       fetch_en;
  logic       in_isr;
  logic       irq_ack;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .ADDR_W      (8),
    .RESET_VECTOR(8'h00),
    .IRQ_VECTOR  (8'hF0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .step    (step),
    .pc_mux  (pc_mux),
    .pc_save (pc_save),
    .skip    (skip),
    .wreg    (wreg),
    .literal (literal),
    .irq     (irq),
    .pc      (pc),
    .fetch_en(fetch_en),
    .in_isr  (in_isr),
    .irq_ack (irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       step;
    logic [1:0] mux;
    logic       ps;
    logic       sk;
    logic [7:0] w;
    logic [7:0] l;
    logic       irq;
    logic [7:0] pc;
    logic       fe;
    logic       isr;
    logic       ack;
  } vec_t;

  vec_t tbl[20];

  // Reference model state: what the program "is doing", not how the RTL encodes it.
  logic [7:0] m_pc;
  logic [7:0] m_saved;
  logic       m_sleep;
  logic       m_isr;
  logic       m_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] e_pc, input logic e_fe,
                            input logic e_isr, input logic e_ack);
    check({tag, ".pc"}, 32'(pc), 32'(e_pc));
    check({tag, ".fetch_en"}, 32'(fetch_en), 32'(e_fe));
    check({tag, ".in_isr"}, 32'(in_isr), 32'(e_isr));
    check({tag, ".irq_ack"}, 32'(irq_ack), 32'(e_ack));
  endtask

  task automatic drive(input logic st, input logic [1:0] mux, input logic ps, input logic sk,
                       input logic [7:0] w, input logic [7:0] l, input logic i);
    step = st; pc_mux = mux; pc_save = ps; skip = sk; wreg = w; literal = l; irq = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_saved = 8'h00; m_sleep = 1'b0; m_isr = 1'b0; m_ack = 1'b0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [7:0] nxt;
    m_ack = 1'b0;
    if (m_sleep) begin
      if (irq) begin
        m_sleep = 1'b0; m_isr = 1'b1; m_pc = 8'hF0; m_ack = 1'b1;
      end
    end else if (step) begin
      if (pc_mux == 2'd0)      nxt = m_pc + 8'd1 + {7'd0, skip};
      else if (pc_mux == 2'd1) nxt = wreg;
      else if (pc_mux == 2'd2) nxt = literal;
      else                     nxt = m_pc + 8'd1;
`ifdef PCSEQ_PREEMPT_EN
      if (!m_isr && irq) begin
        m_saved = nxt; m_pc = 8'hF0; m_isr = 1'b1; m_ack = 1'b1;
      end else
`endif
      if (pc_mux == 2'd3 && pc_save && !m_isr) begin
        m_saved = m_pc + 8'd1; m_sleep = 1'b1;
      end else if (pc_mux == 2'd3 && !pc_save && m_isr) begin
        m_pc = m_saved; m_isr = 1'b0;
      end else begin
        m_pc = nxt;
      end
    end
  endtask

  initial begin
    //          step mux  ps    sk    wreg   lit    irq   pc     fe    isr   ack
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 1'b1, 8'h99, 8'h40, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 8'h22, 8'h77, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    // 20 idle WAIT cycles run between index 9 and 10
    tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hF0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hF1, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hF2, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 2'd3, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'hF3, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 2'd3, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 1'b0, 8'h00, 8'h77, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 2'd1, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};

    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    check_outs("reset", 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_outs("post_reset", 8'h00, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        for (int k = 0; k < 20; k++) begin
          drive(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                8'($urandom), 1'b0);
          tick();
          check("wait_idle.pc", 32'(pc), 32'h10);
          check("wait_idle.fetch_en", 32'(fetch_en), 32'h0);
        end
      end
      drive(tbl[i].step, tbl[i].mux, tbl[i].ps, tbl[i].sk, tbl[i].w, tbl[i].l, tbl[i].irq);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fe, tbl[i].isr, tbl[i].ack);
    end

    // Async reset in the middle of a WAIT cycle, well away from any clock edge.
    drive(1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check("wfi_again.fetch_en", 32'(fetch_en), 32'h0);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    #2 reset = 1'b1;
    #1 check_outs("async_reset_wait", 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Reach ISR, then reset asynchronously while the irq_ack pulse is visible.
    drive(1'b1, 2'd3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    check_outs("isr_entry", 8'hF0, 1'b1, 1'b1, 1'b1);
    irq = 1'b0;
    #2 reset = 1'b1;
    #1 check_outs("async_reset_isr", 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // irq alongside a jump in RUN.
    drive(1'b1, 2'd2, 1'b0, 1'b0, 8'h00, 8'h05, 1'b0);
    tick();
    check("pre_lit.pc", 32'(pc), 32'h05);
    drive(1'b1, 2'd2, 1'b0, 1'b1, 8'h00, 8'h30, 1'b1);
    tick();
`ifdef PCSEQ_PREEMPT_EN
    check_outs("preempt", 8'hF0, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    check_outs("preempt_rfi", 8'h30, 1'b1, 1'b0, 1'b0);
`else
    check_outs("irq_in_run", 8'h30, 1'b1, 1'b0, 1'b0);
`endif

    // Random stimulus against the reference model.
    drive(1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    reset = 1'b1;
    #1 model_reset();
    tick();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(3) != 0), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
            8'($urandom), ($urandom_range(4) == 0));
      model_edge();
      tick();
      check_outs("rand", m_pc, !m_sleep, m_isr, m_ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumes the instruction decoder's pc_mux/pc_save outputs and the ALU skip result, and owns the program counter.
- Computes the next PC each executed instruction (sequential, skip, literal jump, W-register jump).
- Implements wfi (save PC, sleep until irq, vector to ISR) and rfi (restore saved PC).
- Sits between the decoder/ALU and the instruction memory address port.

Parameters:
- ADDR_W, 8, PC and address width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_VECTOR, 0, PC value after reset.
- IRQ_VECTOR, 8'hF0, PC loaded when an interrupt is taken.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- step  input  1  current instruction retires this cycle; PC updates only when step=1.
- pc_mux  input  2  from decoder: 0=ADD, 1=WREG, 2=LIT, 3=SAVE.
- pc_save  input  1  from decoder: qualifies SAVE (1=wfi, 0=rfi).
- skip  input  1  ALU PCZERO/PCZEROBAR result; 1 = skip next instruction.
- wreg  input  ADDR_W  W register value (gow target).
- literal  input  ADDR_W  instruction literal (gol target).
- irq  input  1  level interrupt request.
- pc  output  ADDR_W  current fetch address (registered).
- fetch_en  output  1  1 = instruction memory fetch valid; 0 while sleeping.
- in_isr  output  1  1 while executing the interrupt handler.
- irq_ack  output  1  one-cycle pulse on interrupt entry.

Behaviour:
- Reset (async, any time, including mid-WAIT or mid-ISR): pc=RESET_VECTOR, saved_pc=0, state=RUN, fetch_en=1, in_isr=0, irq_ack=0.
- States: RUN, WAIT, ISR. in_isr=1 in ISR. fetch_en=0 only in WAIT.
- step=0: all state and outputs hold; irq_ack=0.
- RUN/ISR with step=1, by pc_mux:
  - ADD: pc <= pc + 1 + skip, i.e. +1 or +2, wrapping mod 2^ADDR_W.
  - LIT: pc <= literal.
  - WREG: pc <= wreg.
  - SAVE with pc_save=1 (wfi), in RUN: saved_pc <= pc+1; pc holds; state <= WAIT.
  - SAVE with pc_save=0 (rfi), in ISR: pc <= saved_pc; state <= RUN.
  - wfi while in ISR (no nesting): behaves as ADD with skip=0.
  - rfi while in RUN: behaves as ADD with skip=0.
- skip is ignored for all pc_mux values other than ADD.
- WAIT: step is ignored. When irq=1 at a rising edge: pc <= IRQ_VECTOR, state <= ISR, irq_ack=1 for exactly that one cycle.
  - fetch_en returns to 1 in the same cycle that pc shows IRQ_VECTOR.
  - irq=0: remain in WAIT indefinitely.
- irq in RUN or ISR: ignored (base build).
- All outputs are registered; the PC update is visible one cycle after the step edge.

Optional Feature:
- Macro: PCSEQ_PREEMPT_EN.
- Defined: in RUN, irq=1 with step=1 preempts the instruction's PC update.
  - saved_pc <= the next PC the instruction would have produced (including skip/jump).
  - pc <= IRQ_VECTOR; state <= ISR; irq_ack pulses.
  - wfi in the same cycle is overridden, with saved_pc=pc+1.
  - irq in ISR is still ignored.
- Undefined: irq is only honoured in WAIT, exactly as in Behaviour.

Test Plan:
- Reset then 3 steps of ADD, skip=0 -> pc 0,1,2,3. Then ADD with skip=1 -> pc=5. From pc=8'hFF, ADD with skip=1 -> pc=8'h01 (wrap).
- LIT with literal=8'h40 -> pc=8'h40. Then WREG with wreg=8'h22 -> pc=8'h22. Drive skip=1 during both -> no effect.
- At pc=8'h10: wfi -> fetch_en=0, pc holds 8'h10. Hold irq=0 for 20 cycles -> no change. Raise irq -> pc=8'hF0, irq_ack high for one cycle, in_isr=1, fetch_en=1.
- In ISR: ADD x2 -> pc=8'hF2. Then rfi -> pc=8'h11, in_isr=0. Then rfi in RUN -> pc=8'h12.
- Assert reset asynchronously mid-WAIT and mid-ISR -> outputs return immediately to reset values, with no clock edge needed. Also toggle step=0 with varied pc_mux -> pc unchanged.
- With PCSEQ_PREEMPT_EN at pc=8'h05: LIT literal=8'h30 plus irq -> pc=8'hF0. Later rfi -> pc=8'h30. Without the macro, the same stimulus gives pc=8'h30 and irq is ignored.
